// File: rtl/dds_lookup_table.sv
// Phase-to-amplitude converter for the DDS datapath.
// Returns sin(x) and cos(2x) in Q2.30, x = 2*pi*Adddress/2048. A 513-entry
// quarter-wave sine table serves both paths through quadrant mirroring and
// sign flip. The table is evaluated at elaboration time, so no external
// memory image is needed. The pipeline is two clocks deep: index, then data.
module dds_lookup_table (
    input  logic        Fg_CLK,
    input  logic        RESETn,
    input  logic [10:0] Adddress,
    output logic [31:0] sin1x,
    output logic [31:0] cos2x,
    output logic [15:0] out1,
    output logic [15:0] out2
);

    // round(sin(pi/2 * j/512) * 2^30), evaluated with a Taylor series so the
    // table is a pure elaboration-time constant.
    function automatic logic [31:0] sine_entry(input int j);
        real x;
        real term;
        real sum;
        real scaled;
        x    = (3.14159265358979323846 / 2.0) * real'(j) / 512.0;
        term = x;
        sum  = x;
        for (int n = 1; n < 20; n++) begin
            term = -term * x * x / ((2.0 * real'(n)) * (2.0 * real'(n) + 1.0));
            sum  = sum + term;
        end
        scaled = sum * 1073741824.0 + 0.5;
        return 32'($rtoi(scaled));
    endfunction

    // Quarter-wave index: odd quadrants read the table backwards, so k=0
    // there lands on T[512].
    function automatic logic [9:0] mirror_index(input logic [10:0] p);
        logic [9:0] k_ext;
        k_ext = {1'b0, p[8:0]};
        if (p[9]) begin
            return 10'd512 - k_ext;
        end else begin
            return k_ext;
        end
    endfunction

    logic [31:0] rom_s [0:512];

    for (genvar g = 0; g < 513; g++) begin : g_rom
        localparam logic [31:0] ENTRY = sine_entry(g);
        assign rom_s[g] = ENTRY;
    end

    // Stage 1 registers: phase, sign and mirrored index for both paths.
    logic [10:0] p_s_d, p_s_q;
    logic [10:0] p_c_d, p_c_q;
    logic [9:0]  idx_s_d, idx_s_q;
    logic [9:0]  idx_c_d, idx_c_q;
    logic        neg_s_d, neg_s_q;
    logic        neg_c_d, neg_c_q;

    // Stage 2 registers: signed samples.
    logic [31:0] sin_d, sin_q;
    logic [31:0] cos_d, cos_q;

    // Stage 1 next state: phases for sin(x) and sin(2x + pi/2) = cos(2x).
    always_comb begin
        p_s_d   = Adddress;
        p_c_d   = {Adddress[9:0], 1'b0} + 11'd512;
        neg_s_d = p_s_d[10];
        neg_c_d = p_c_d[10];
        idx_s_d = mirror_index(p_s_d);
        idx_c_d = mirror_index(p_c_d);
    end

    // Stage 1 pipeline register with synchronous clear.
    always_ff @(posedge Fg_CLK) begin
        if (RESETn) begin
            p_s_q   <= 11'd0;
            p_c_q   <= 11'd0;
            idx_s_q <= 10'd0;
            idx_c_q <= 10'd0;
            neg_s_q <= 1'b0;
            neg_c_q <= 1'b0;
        end else begin
            p_s_q   <= p_s_d;
            p_c_q   <= p_c_d;
            idx_s_q <= idx_s_d;
            idx_c_q <= idx_c_d;
            neg_s_q <= neg_s_d;
            neg_c_q <= neg_c_d;
        end
    end

    // Stage 2 next state: two table reads with the sign applied. Negating
    // T[0] gives 32'd0 naturally in two's complement.
    always_comb begin
        if (neg_s_q) begin
            sin_d = 32'd0 - rom_s[idx_s_q];
        end else begin
            sin_d = rom_s[idx_s_q];
        end
        if (neg_c_q) begin
            cos_d = 32'd0 - rom_s[idx_c_q];
        end else begin
            cos_d = rom_s[idx_c_q];
        end
    end

    // Stage 2 output register with synchronous clear.
    always_ff @(posedge Fg_CLK) begin
        if (RESETn) begin
            sin_q <= 32'd0;
            cos_q <= 32'd0;
        end else begin
            sin_q <= sin_d;
            cos_q <= cos_d;
        end
    end

    assign sin1x = sin_q;
    assign cos2x = cos_q;
    assign out1  = sin_q[31:16];
    assign out2  = cos_q[31:16];

    // The phases themselves are kept in stage 1 for visibility when debugging
    // and are folded into the sign/index fields that drive stage 2.
    logic unused_phase_s;
    assign unused_phase_s = ^{p_s_q, p_c_q};

endmodule

// File: tb/tb_dds_lookup_table.sv
// Self-checking bench for dds_lookup_table: a trig-based golden model fed by
// the same inputs, delayed by the two-clock latency, checked every cycle.
module tb_dds_lookup_table;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] addr = 11'd0;
    logic [31:0] sin1x;
    logic [31:0] cos2x;
    logic [15:0] out1;
    logic [15:0] out2;

    int n_checks = 0;
    int n_pass   = 0;

    dds_lookup_table dut (
        .Fg_CLK  (clk),
        .RESETn  (rst),
        .Adddress(addr),
        .sin1x   (sin1x),
        .cos2x   (cos2x),
        .out1    (out1),
        .out2    (out2)
    );

    always #5 clk = ~clk;

    localparam real PI = 3.14159265358979323846;

    function automatic logic [31:0] q30(input real v);
        real s;
        s = v * 1073741824.0;
        if (s >= 0.0) return 32'($rtoi(s + 0.5));
        else          return 32'(-$rtoi(-s + 0.5));
    endfunction

    function automatic logic [31:0] gold_sin(input int a);
        return q30($sin(2.0 * PI * real'(a) / 2048.0));
    endfunction

    function automatic logic [31:0] gold_cos(input int a);
        return q30($cos(4.0 * PI * real'(a) / 2048.0));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    endtask

    // Input history seen at each rising edge.
    logic        rst_e0 = 1'b1, rst_e1 = 1'b1;
    logic [10:0] a_e0 = 11'd0, a_e1 = 11'd0;
    logic        primed = 1'b0;

    always @(posedge clk) begin
        rst_e0 <= rst;
        rst_e1 <= rst_e0;
        a_e0   <= addr;
        a_e1   <= a_e0;
        if (rst) primed <= 1'b1;
    end

    // Every-cycle compare: a reset at this edge or the previous one gives 0,
    // otherwise the golden value of the address presented two edges back.
    always @(negedge clk) begin
        logic [31:0] es, ec;
        if (primed) begin
            if (rst_e0 || rst_e1) begin
                es = 32'd0;
                ec = 32'd0;
            end else begin
                es = gold_sin(int'(a_e1));
                ec = gold_cos(int'(a_e1));
            end
            check("sin1x", sin1x, es);
            check("cos2x", cos2x, ec);
            check("out1", {16'd0, out1}, {16'd0, es[31:16]});
            check("out2", {16'd0, out2}, {16'd0, ec[31:16]});
        end
    end

    task automatic cyc(input int a, input logic r);
        addr = 11'(a);
        rst  = r;
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input int a, input int n);
        for (int i = 0; i < n; i++) cyc(a, 1'b0);
    endtask

    initial begin
        // Pin the model against hand-computed values.
        check("model_sin256", gold_sin(256), 32'h2D413CCD);
        check("model_cos256", gold_cos(256), 32'h00000000);
        check("model_sin512", gold_sin(512), 32'h40000000);
        check("model_cos512", gold_cos(512), 32'hC0000000);
        check("model_sin1536", gold_sin(1536), 32'hC0000000);
        check("model_cos0", gold_cos(0), 32'h40000000);
        for (int a = 0; a < 1024; a += 97) begin
            check("model_sym_sin", gold_sin(a), 32'd0 - gold_sin(a + 1024));
            check("model_sym_cos", gold_cos(a), gold_cos(a + 1024));
        end

        // Reset held with a nonzero address.
        for (int i = 0; i < 10; i++) cyc(5, 1'b1);
        check("rst_sin", sin1x, 32'd0);
        check("rst_cos", cos2x, 32'd0);
        check("rst_out1", {16'd0, out1}, 32'd0);
        check("rst_out2", {16'd0, out2}, 32'd0);

        // Release with A=0.
        hold(0, 3);
        check("a0_sin", sin1x, 32'h00000000);
        check("a0_cos", cos2x, 32'h40000000);
        check("a0_out1", {16'd0, out1}, 32'h00000000);
        check("a0_out2", {16'd0, out2}, 32'h00004000);

        // Cardinal points.
        hold(256, 3);
        check("c256_sin", sin1x, 32'h2D413CCD);
        check("c256_cos", cos2x, 32'h00000000);
        hold(512, 3);
        check("c512_sin", sin1x, 32'h40000000);
        check("c512_cos", cos2x, 32'hC0000000);
        hold(1024, 3);
        check("c1024_sin", sin1x, 32'h00000000);
        check("c1024_cos", cos2x, 32'h40000000);
        hold(1536, 3);
        check("c1536_sin", sin1x, 32'hC0000000);
        check("c1536_cos", cos2x, 32'hC0000000);
        check("c1536_out1", {16'd0, out1}, 32'h0000C000);

        // Small steps, each held long enough to show stability.
        hold(1, 100);
        hold(2, 100);
        hold(3, 100);

        // Clean sweep.
        for (int a = 0; a < 2048; a++) cyc(a, 1'b0);

        // Sweep with a single reset cycle at A=700.
        for (int a = 0; a < 2048; a++) cyc(a, (a == 700) ? 1'b1 : 1'b0);
        hold(2047, 2);

        // Random addresses with sporadic resets.
        for (int i = 0; i < 600; i++) begin
            cyc(int'($urandom_range(0, 2047)), ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0);
        end
        hold(0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
